data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Parameters
REQ-001 DEPTH, default 64, number of 32-bit data words; legal byte addresses are 0 to 4*DEPTH-1.
REQ-002 LATENCY, default 2, cycles from request acceptance to completion; legal range 1 to 15.

Interface
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 read_En  input  1  load request from MEMstage.
REQ-006 write_En  input  1  store request from MEMstage.
REQ-007 DataAddress  input  32  byte address of the access.
REQ-008 WriteData  input  32  store data.
REQ-009 ReadData  output  32  registered load result; valid in the DONE cycle.
REQ-010 mem_stall  output  1  freeze request to the pipeline while an access is pending.
REQ-011 ready  output  1  one-cycle pulse marking access completion.
REQ-012 addr_err  output  1  sticky error flag: misaligned or out-of-range access.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-014 In IDLE, a request (read_En or write_En high) SHALL be accepted; DataAddress, WriteData and the request type are captured at that edge.
REQ-015 On acceptance with LATENCY=1 the FSM SHALL go to DONE; otherwise it SHALL go to WAIT with a 4-bit counter loaded with LATENCY-2.
REQ-016 WAIT SHALL decrement the counter each cycle and go to DONE on the edge where the counter is 0.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE; a request present during DONE SHALL be ignored, because the pipeline advances in that cycle.
REQ-018 Timing: a request sampled in IDLE at cycle N SHALL produce ready=1 in cycle N+LATENCY only.
REQ-019 mem_stall SHALL be driven as follows:
- high combinationally in IDLE while a request is present;
- high throughout WAIT;
- low in DONE and in IDLE with no request.
REQ-020 If read_En and write_En are both high at acceptance, the access SHALL be a write; addr_err is not set for this case.
REQ-021 Word index SHALL be DataAddress[log2(DEPTH)+1:2].
REQ-022 The access SHALL be invalid if DataAddress[1:0] is not 0 or DataAddress >= 4*DEPTH.
REQ-023 An invalid access SHALL:
- leave memory untouched;
- return ReadData=0;
- set addr_err at the edge entering DONE;
- still complete with normal timing.
REQ-024 A valid write SHALL commit to memory at the edge entering DONE; ReadData SHALL hold its previous value.
REQ-025 A valid read SHALL load ReadData from memory at the edge entering DONE; ReadData SHALL hold until the next completed read.
REQ-026 Inputs SHALL be sampled only at acceptance; input changes during WAIT have no effect.
REQ-027 addr_err SHALL clear only on reset.

Reset
REQ-028 Reset assertion SHALL immediately force the following, independent of clk:
- state=IDLE, counter=0;
- ReadData=0, ready=0, addr_err=0;
- all memory words=0.
- mem_stall then follows REQ-019 for IDLE.
REQ-029 Reset during WAIT SHALL abort the access; a pending write SHALL NOT commit.
REQ-030 After reset deassertion, the first rising edge with a request present SHALL accept it.

Verification
REQ-031 Store then load: write 0xDEADBEEF to addr 0x10 with LATENCY=2, then read 0x10. Required:
- each access stalls 2 cycles;
- ready pulses in cycle N+2;
- ReadData=0xDEADBEEF.
REQ-032 Misaligned read at 0x13. Required: ready at N+2, ReadData=0, addr_err=1 and remains 1 through a later valid access.
REQ-033 Out-of-range write at 0x100 (DEPTH=64) of 0x1234. Required: addr_err=1; a subsequent read of word 0 and word 63 returns 0.
REQ-034 read_En=write_En=1, addr 0x20, data 0xA5A5A5A5. Required: treated as a write; a later read of 0x20 returns 0xA5A5A5A5; addr_err=0.
REQ-035 Write of 0x55 to 0x08, reset asserted mid-WAIT, then a read of 0x08. Required:
- outputs are reset values immediately;
- the read returns 0.
REQ-036 Back-to-back requests held high with LATENCY=1. Required:
- ready pulses every 2 cycles;
- mem_stall pattern is 1,0 repeating;
- the request in the DONE cycle is ignored.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory seen by the MEM stage: accepts one load or store,
// stalls the pipeline for LATENCY cycles, then completes with a one-cycle ready pulse.
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_En,
  input  logic        write_En,
  input  logic [31:0] DataAddress,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        mem_stall,
  output logic        ready,
  output logic        addr_err
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT     = 33'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        isWrite_q;
  logic [31:0] readData_q;
  logic        addrErr_q;
  logic [31:0] mem_q [DEPTH];

  logic          req;
  logic          useLive;
  logic [31:0]   accAddr;
  logic [31:0]   accData;
  logic          accWrite;
  logic          accInvalid;
  logic [AW-1:0] accIdx;
  logic          enterDone;

  assign req = read_En | write_En;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (LATENCY <= 1) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY=1 the access completes on the accepting edge, before the
  // capture registers are loaded, so the live inputs are used in IDLE.
  always_comb begin
    useLive    = (state_q == IDLE);
    accAddr    = useLive ? DataAddress : addr_q;
    accData    = useLive ? WriteData   : wdata_q;
    accWrite   = useLive ? write_En    : isWrite_q;
    accInvalid = (accAddr[1:0] != 2'b00) || ({1'b0, accAddr} >= LIMIT);
    accIdx     = accAddr[AW+1:2];
    enterDone  = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      isWrite_q  <= 1'b0;
      readData_q <= '0;
      addrErr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        addr_q    <= DataAddress;
        wdata_q   <= WriteData;
        isWrite_q <= write_En;
      end
      if (enterDone && !accWrite) begin
        readData_q <= accInvalid ? 32'd0 : mem_q[accIdx];
      end
      if (enterDone && accInvalid) begin
        addrErr_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (enterDone && accWrite && !accInvalid) begin
      mem_q[accIdx] <= accData;
    end
  end

  assign ReadData  = readData_q;
  assign addr_err  = addrErr_q;
  assign ready     = (state_q == DONE);
  assign mem_stall = (state_q == WAIT) || ((state_q == IDLE) && req);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=2 instance driven by directed
// accesses and a LATENCY=1 instance exercised with back-to-back held requests.
module tb_data_mem_responder;

  localparam int LAT = 2;

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        err;
    string       name;
  } sbEntry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        readEn, writeEn;
  logic [31:0] dataAddress, writeData;
  logic [31:0] readData;
  logic        memStall, ready, addrErr;

  logic        readEn1, writeEn1;
  logic [31:0] dataAddress1, writeData1;
  logic [31:0] readData1;
  logic        memStall1, ready1, addrErr1;

  int       cycleCnt = 0;
  int       checks   = 0;
  int       failures = 0;
  sbEntry_t sbQueue[$];

  data_mem_responder #(.DEPTH(64), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .read_En(readEn), .write_En(writeEn),
    .DataAddress(dataAddress), .WriteData(writeData), .ReadData(readData),
    .mem_stall(memStall), .ready(ready), .addr_err(addrErr)
  );

  data_mem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .read_En(readEn1), .write_En(writeEn1),
    .DataAddress(dataAddress1), .WriteData(writeData1), .ReadData(readData1),
    .mem_stall(memStall1), .ready(ready1), .addr_err(addrErr1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one access in an IDLE cycle, scramble inputs during WAIT, and return
  // after the DONE cycle so the next call starts in IDLE.
  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [31:0] expRd, input logic expErr);
    sbEntry_t e;
    @(negedge clk);
    readEn = rd; writeEn = wr; dataAddress = addr; writeData = data;
    #1 checkOutput({name, " stall in IDLE"}, 32'(memStall), 32'd1);
    e.cyc = cycleCnt + LAT; e.rd = expRd; e.err = expErr; e.name = name;
    sbQueue.push_back(e);
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      if (i == 1) begin
        readEn = 1'b0; writeEn = 1'b0;
        dataAddress = 32'hFFFF_FFF3; writeData = 32'h0BAD_0BAD;
      end
      #1 checkOutput({name, " stall"}, 32'(memStall), (i < LAT) ? 32'd1 : 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && ready) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected ready", 32'd1, 32'd0);
      end else begin
        sbEntry_t e;
        e = sbQueue.pop_front();
        checkOutput({e.name, " ready cycle"}, 32'(cycleCnt), 32'(e.cyc));
        checkOutput({e.name, " ReadData"}, readData, e.rd);
        checkOutput({e.name, " addr_err"}, 32'(addrErr), 32'(e.err));
      end
    end
  end

  initial begin
    reset = 1'b1;
    readEn = 1'b0; writeEn = 1'b0; dataAddress = '0; writeData = '0;
    readEn1 = 1'b0; writeEn1 = 1'b0; dataAddress1 = '0; writeData1 = '0;
    #2;
    checkOutput("reset ReadData", readData, 32'd0);
    checkOutput("reset ready", 32'(ready), 32'd0);
    checkOutput("reset addr_err", 32'(addrErr), 32'd0);
    checkOutput("reset mem_stall", 32'(memStall), 32'd0);
    @(negedge clk); reset = 1'b0;

    applyStimulus("wr 0x10",        1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
    applyStimulus("rd 0x10",        1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    applyStimulus("rd misaligned",  1'b1, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1);
    applyStimulus("rd 0x10 sticky", 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b1);
    applyStimulus("wr 0x100 oor",   1'b0, 1'b1, 32'h100, 32'h1234,     32'hDEADBEEF, 1'b1);
    applyStimulus("rd word0",       1'b1, 1'b0, 32'h0,   32'h0,        32'h0,        1'b1);
    applyStimulus("rd word63",      1'b1, 1'b0, 32'hFC,  32'h0,        32'h0,        1'b1);
    applyStimulus("rd 0x10 again",  1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b1);

    @(negedge clk); reset = 1'b1;
    #1;
    checkOutput("pulse reset addr_err", 32'(addrErr), 32'd0);
    checkOutput("pulse reset ReadData", readData, 32'd0);
    @(negedge clk); reset = 1'b0;

    applyStimulus("rdwr 0x20",      1'b1, 1'b1, 32'h20,  32'hA5A5A5A5, 32'h0,        1'b0);
    applyStimulus("rd 0x10 cleared",1'b1, 1'b0, 32'h10,  32'h0,        32'h0,        1'b0);
    applyStimulus("rd 0x20",        1'b1, 1'b0, 32'h20,  32'h0,        32'hA5A5A5A5, 1'b0);

    // Write to 0x08 aborted by a reset landing mid-WAIT, between clock edges.
    @(negedge clk);
    writeEn = 1'b1; dataAddress = 32'h08; writeData = 32'h55;
    @(negedge clk);
    writeEn = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("abort ReadData", readData, 32'd0);
    checkOutput("abort ready", 32'(ready), 32'd0);
    checkOutput("abort addr_err", 32'(addrErr), 32'd0);
    checkOutput("abort mem_stall", 32'(memStall), 32'd0);
    @(negedge clk); reset = 1'b0;

    applyStimulus("rd 0x08 after abort", 1'b1, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
    applyStimulus("rd 0x20 after reset", 1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

    // LATENCY=1: held write then held read; DONE-cycle requests are ignored.
    @(negedge clk);
    writeEn1 = 1'b1; dataAddress1 = 32'h04; writeData1 = 32'h11;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 4) begin
        writeEn1 = 1'b0; readEn1 = 1'b1; writeData1 = 32'h77;
      end
      #1;
      checkOutput($sformatf("b2b stall k=%0d", k), 32'(memStall1), (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("b2b ready k=%0d", k), 32'(ready1), (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k == 5 || k == 7) checkOutput($sformatf("b2b ReadData k=%0d", k), readData1, 32'h11);
    end
    readEn1 = 1'b0;
    checkOutput("b2b addr_err", 32'(addrErr1), 32'd0);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sbQueue.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
